// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings and
// the counter-width helper.
package serial_adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit counter must be able to hold WIDTH after the final increment.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder cell reused LSB-first over WIDTH clocks, with a
// start/busy/done handshake and a registered carry loop.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CntW-1:0]  cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_sum),
    .co (fa_cout)
  );

  // New sum bit enters at the MSB so the LSB-first result ends up aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_sum;
    end else begin : g_res_wn
      assign res_next = {fa_sum, res_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            carry  <= cin;
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            sum   <= res_next;
            cout  <= fa_cout;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized scoreboard bench for serial_adder_ctrl (WIDTH=8) plus a WIDTH=1 smoke check.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         cin1;
  logic         busy1;
  logic         done1;
  logic [0:0]   sum1;
  logic         cout1;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  typedef struct packed {
    logic [W:0] val;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         acc_valid = 1'b0;
  int         acc_k = 0;
  logic [W:0] last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Reference model: an add is accepted when start is seen at an edge and the previous
  // add (WIDTH run cycles plus one done cycle) has fully retired.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      acc_valid = 1'b0;
      q.delete();
      last = '0;
    end else if (start && (!acc_valid || cyc > acc_k + W + 1)) begin
      exp_t e;
      acc_valid = 1'b1;
      acc_k     = cyc;
      e.val     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.due     = cyc + W;
      q.push_back(e);
    end
  end

  // Monitor: busy/done timing every cycle, result on done, hold between dones.
  initial forever begin
    logic exp_busy;
    logic exp_done;
    @(negedge clk);
    if (cyc >= 1) begin
      exp_busy = acc_valid && cyc >= acc_k && cyc <= acc_k + W;
      exp_done = acc_valid && cyc == acc_k + W;
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("done", {31'd0, done}, {31'd0, exp_done});
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("done_without_request", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", {23'd0, cout, sum}, {23'd0, e.val});
          check("done_cycle", cyc, e.due);
          last = e.val;
        end
      end else begin
        check("hold", {23'd0, cout, sum}, {23'd0, last});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (acc_valid && cyc < acc_k + W + 1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 100) begin
        check("wait_ready_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    wait_ready();
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts negedges from the accept edge until done; checks latency and the constant result.
  task automatic wait_done(input string name, input logic [W:0] want);
    int n = 0;
    bit seen = 1'b0;
    while (n < 30 && !seen) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({name, "_latency"}, n, W + 1);
    check({name, "_value"}, {23'd0, cout, sum}, {23'd0, want});
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy1", {31'd0, busy1}, 32'd0);
    check("reset_out1", {30'd0, cout1, sum1}, 32'd0);
    rst = 1'b0;

    // WIDTH=1 build: done two cycles after start
    begin
      int n = 0;
      bit seen = 1'b0;
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      while (n < 10 && !seen) begin
        @(negedge clk);
        n++;
        if (done1 === 1'b1) seen = 1'b1;
      end
      check("w1_latency", n, 32'd2);
      check("w1_value", {30'd0, cout1, sum1}, 32'd3);
    end

    add(8'h5A, 8'h3C, 1'b0);
    wait_done("add_5a_3c", 9'h096);
    add(8'hFF, 8'h01, 1'b0);
    wait_done("add_ff_01", 9'h100);
    add(8'hFF, 8'hFF, 1'b1);
    wait_done("add_ff_ff_c", 9'h1FF);

    // Start re-pulsed during RUN with other operands must be ignored.
    add(8'h33, 8'h44, 1'b0);
    @(posedge clk);
    #1;
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      int n = 0;
      while (n < 30 && done !== 1'b1) begin
        @(negedge clk);
        n++;
      end
      check("ignore_busy_start", {23'd0, cout, sum}, 32'h077);
    end

    // Reset mid-run aborts the add and clears outputs.
    add(8'h10, 8'h20, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out", {23'd0, cout, sum}, 32'd0);
    add(8'h10, 8'h20, 1'b0);
    wait_done("after_abort", 9'h030);

    // Start held high with operands stepping every cycle.
    wait_ready();
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      a   = W'(i * 7);
      b   = W'(i * 13 + 5);
      cin = i[0];
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      add(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 12)) begin
        @(posedge clk);
        #1;
      end
    end

    begin
      int n = 0;
      while (q.size() != 0 && n < 50) begin
        @(posedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
